// File: rtl/low_papr_seq_ctrl_pkg.sv
// Shared definitions for the low-PAPR base-sequence sequencer: length encodings,
// legality limits and the 3*phi mod 24 phase table.
package low_papr_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    LenM6  = 2'd0,
    LenM12 = 2'd1,
    LenM18 = 2'd2,
    LenM24 = 2'd3
  } len_sel_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [4:0] U_MAX     = 5'd29;
  localparam logic [3:0] NCS_MAX   = 4'd11;
  localparam logic [5:0] PHASE_MOD = 6'd24;

  function automatic logic [4:0] seq_len(input logic [1:0] sel);
    logic [4:0] m;
    unique case (len_sel_e'(sel))
      LenM6:   m = 5'd6;
      LenM12:  m = 5'd12;
      LenM18:  m = 5'd18;
      default: m = 5'd24;
    endcase
    return m;
  endfunction

  // ROM code c encodes phi = 2c-3; this returns 3*phi mod 24.
  function automatic logic [4:0] phi3_mod24(input logic [1:0] code);
    logic [4:0] p;
    unique case (code)
      2'b00:   p = 5'd15;
      2'b01:   p = 5'd21;
      2'b10:   p = 5'd3;
      default: p = 5'd9;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/low_papr_seq_ctrl_if.sv
// Output element stream from the sequencer to the modulator (valid/ready).
interface low_papr_seq_ctrl_if #(
  parameter int unsigned CNT_W = 10,
  parameter int unsigned PH_W  = 5
);
  logic             out_valid;
  logic             out_ready;
  logic [PH_W-1:0]  out_phase;
  logic [CNT_W-1:0] out_idx;
  logic             out_sym_last;
  logic             out_last;

  modport master (
    output out_valid, out_phase, out_idx, out_sym_last, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_phase, out_idx, out_sym_last, out_last,
    output out_ready
  );
endinterface

// File: rtl/low_papr_phase_calc.sv
// Combines a ROM phase code with the cyclic-shift ramp into a phase index mod 24.
module low_papr_phase_calc
  import low_papr_seq_ctrl_pkg::*;
(
  input  logic [1:0] code,
  input  logic [4:0] acc,
  output logic [4:0] phase
);
  logic [5:0] sum;

  always_comb begin
    sum   = {1'b0, phi3_mod24(code)} + {1'b0, acc};
    phase = (sum >= PHASE_MOD) ? 5'(sum - PHASE_MOD) : sum[4:0];
  end
endmodule

// File: rtl/low_papr_seq_ctrl.sv
// Walks the low-PAPR phase ROM for one or more repetitions and streams phase indices
// through a single-stage output register.
module low_papr_seq_ctrl
  import low_papr_seq_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 10,
  parameter int unsigned PH_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       u_in,
  input  logic [1:0]       len_sel,
  input  logic [3:0]       n_cs,
  input  logic [1:0]       n_rep,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [4:0]       rom_u,
  output logic [1:0]       rom_sel,
  output logic [CNT_W-1:0] rom_counter,
  input  logic [1:0]       rom_phi,
  low_papr_seq_ctrl_if.master dout
);
  state_e           state_q, state_d;
  logic [4:0]       u_q;
  logic [1:0]       sel_q, nrep_q, rep_q;
  logic [3:0]       ncs_q;
  logic [CNT_W-1:0] counter_q, idx_q;
  logic [4:0]       acc_q, acc_next, phase_w;
  logic [5:0]       acc_sum;
  logic             fin_q, err_q, valid_q, sym_last_q, last_q;
  logic [PH_W-1:0]  phase_q;

  logic       idle_start, legal, accept, load, hs, last_elem, final_elem;
  logic [1:0] cur_sel, cur_nrep;
  logic [3:0] cur_ncs;

  // On the accepting cycle the raw inputs feed the ROM and datapath so that
  // element 0 is registered at the start edge (latency 1).
  always_comb begin
    idle_start = (state_q == StIdle) && start;
    legal      = (u_in <= U_MAX) && (n_cs <= NCS_MAX);
    accept     = idle_start && legal;
    cur_sel    = accept ? len_sel : sel_q;
    cur_ncs    = accept ? n_cs : ncs_q;
    cur_nrep   = accept ? n_rep : nrep_q;
    hs         = valid_q && dout.out_ready;
    load       = accept || ((state_q == StRun) && (!valid_q || dout.out_ready) && !fin_q);
    last_elem  = (counter_q == CNT_W'(seq_len(cur_sel) - 5'd1));
    final_elem = last_elem && (rep_q == cur_nrep);
    acc_sum    = {1'b0, acc_q} + {1'b0, cur_ncs, 1'b0};
    acc_next   = (acc_sum >= PHASE_MOD) ? 5'(acc_sum - PHASE_MOD) : acc_sum[4:0];
  end

  low_papr_phase_calc u_phase_calc (
    .code  (rom_phi),
    .acc   (acc_q),
    .phase (phase_w)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (hs && last_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_q        <= '0;
      sel_q      <= '0;
      ncs_q      <= '0;
      nrep_q     <= '0;
      rep_q      <= '0;
      counter_q  <= '0;
      acc_q      <= '0;
      fin_q      <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      phase_q    <= '0;
      idx_q      <= '0;
      sym_last_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      err_q <= idle_start && !legal;
      if (accept) begin
        u_q    <= u_in;
        sel_q  <= len_sel;
        ncs_q  <= n_cs;
        nrep_q <= n_rep;
        fin_q  <= 1'b0;
      end
      if (load) begin
        valid_q    <= 1'b1;
        phase_q    <= PH_W'(phase_w);
        idx_q      <= counter_q;
        sym_last_q <= last_elem;
        last_q     <= final_elem;
        if (last_elem) begin
          counter_q <= '0;
          acc_q     <= '0;
          rep_q     <= final_elem ? 2'd0 : rep_q + 2'd1;
          fin_q     <= final_elem;
        end else begin
          counter_q <= counter_q + 1'b1;
          acc_q     <= acc_next;
        end
      end else if (hs) begin
        valid_q    <= 1'b0;
        sym_last_q <= 1'b0;
        last_q     <= 1'b0;
      end
    end
  end

  always_comb begin
    busy              = (state_q == StRun);
    done              = (state_q == StDone);
    err               = err_q;
    rom_u             = accept ? u_in : u_q;
    rom_sel           = cur_sel;
    rom_counter       = counter_q;
    dout.out_valid    = valid_q;
    dout.out_phase    = phase_q;
    dout.out_idx      = idx_q;
    dout.out_sym_last = sym_last_q;
    dout.out_last     = last_q;
  end
endmodule

// File: tb/tb_low_papr_seq_ctrl.sv
// Directed bench for low_papr_seq_ctrl with a table-driven phase ROM model.
module tb_low_papr_seq_ctrl;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned PH_W  = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [4:0]       u_in = '0;
  logic [1:0]       len_sel = '0;
  logic [3:0]       n_cs = '0;
  logic [1:0]       n_rep = '0;
  logic             busy, done, err;
  logic [4:0]       rom_u;
  logic [1:0]       rom_sel;
  logic [CNT_W-1:0] rom_counter;
  logic [1:0]       rom_phi;
  logic [1:0]       rom_tbl [24];

  low_papr_seq_ctrl_if #(.CNT_W(CNT_W), .PH_W(PH_W)) sif ();

  low_papr_seq_ctrl #(.CNT_W(CNT_W), .PH_W(PH_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .u_in        (u_in),
    .len_sel     (len_sel),
    .n_cs        (n_cs),
    .n_rep       (n_rep),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rom_u       (rom_u),
    .rom_sel     (rom_sel),
    .rom_counter (rom_counter),
    .rom_phi     (rom_phi),
    .dout        (sif)
  );

  always #5 clk = ~clk;

  assign rom_phi = (rom_counter < 10'd24) ? rom_tbl[rom_counter[4:0]] : 2'd0;

  int n_vec = 0;
  int n_err = 0;
  int cap [$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_phase(input int n, input int ncs);
    int t3;
    case (rom_tbl[n])
      2'd0:    t3 = 15;
      2'd1:    t3 = 21;
      2'd2:    t3 = 3;
      default: t3 = 9;
    endcase
    return (t3 + 2 * ncs * n) % 24;
  endfunction

  task automatic run_seq(input logic [4:0] u, input logic [1:0] sel, input logic [3:0] ncs,
                         input logic [1:0] rep, input bit bp, input bit poke_done);
    int m, total, got, cyc;
    bit stalled;
    int hold_ph, hold_idx;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    m = 6 * (int'(sel) + 1);
    total = m * (int'(rep) + 1);
    got = 0;
    cyc = 0;
    stalled = 0;
    hold_ph = 0;
    hold_idx = 0;
    cap.delete();
    @(posedge clk); #1;
    start = 1'b1; u_in = u; len_sel = sel; n_cs = ncs; n_rep = rep;
    sif.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sif.out_ready = bp ? pat[0] : 1'b1;
    @(negedge clk);
    check_eq("first_valid", sif.out_valid, 1);
    check_eq("busy_run", busy, 1);
    while (1) begin
      if (stalled) begin
        check_eq("stall_valid", sif.out_valid, 1);
        check_eq("stall_phase", sif.out_phase, hold_ph);
        check_eq("stall_idx", sif.out_idx, hold_idx);
      end
      if (sif.out_valid) begin
        check_eq("idx", sif.out_idx, got % m);
        check_eq("phase", sif.out_phase, exp_phase(got % m, ncs));
        check_eq("sym_last", sif.out_sym_last, int'((got % m) == m - 1));
        check_eq("last", sif.out_last, int'(got == total - 1));
        if (sif.out_ready) begin
          cap.push_back(int'(sif.out_phase));
          got++;
        end
      end
      stalled = sif.out_valid && !sif.out_ready;
      hold_ph = sif.out_phase;
      hold_idx = sif.out_idx;
      @(posedge clk); #1;
      cyc++;
      sif.out_ready = bp ? pat[cyc % 4] : 1'b1;
      if (got == total || cyc >= 300) break;
      @(negedge clk);
    end
    check_eq("count", got, total);
    if (poke_done) begin
      start = 1'b1; u_in = 5'd1; len_sel = 2'd0; n_cs = 4'd0; n_rep = 2'd0;
    end
    @(negedge clk);
    check_eq("done_pulse", done, 1);
    check_eq("done_busy", busy, 0);
    check_eq("done_valid", sif.out_valid, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("done_clear", done, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_valid", sif.out_valid, 0);
  endtask

  task automatic illegal_start(input logic [4:0] u, input logic [3:0] ncs);
    @(posedge clk); #1;
    start = 1'b1; u_in = u; n_cs = ncs; len_sel = 2'd0; n_rep = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("err_pulse", err, 1);
    check_eq("err_busy", busy, 0);
    @(negedge clk);
    check_eq("err_clear", err, 0);
    check_eq("err_busy2", busy, 0);
  endtask

  initial begin
    int exp1 [6];
    int exp2 [6];
    exp1 = '{9, 3, 21, 21, 3, 9};
    exp2 = '{9, 5, 1, 3, 11, 19};
    rom_tbl[0] = 2'd3; rom_tbl[1] = 2'd2; rom_tbl[2] = 2'd1;
    rom_tbl[3] = 2'd1; rom_tbl[4] = 2'd2; rom_tbl[5] = 2'd3;
    for (int i = 6; i < 24; i++) rom_tbl[i] = 2'((i * 3 + 1) % 4);
    sif.out_ready = 1'b0;

    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_valid", sif.out_valid, 0);
    check_eq("rst_counter", rom_counter, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_seq(5'd0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      check_eq("hand_ncs0", (i < cap.size()) ? cap[i] : -1, exp1[i]);

    run_seq(5'd0, 2'd0, 4'd1, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      check_eq("hand_ncs1", (i < cap.size()) ? cap[i] : -1, exp2[i]);

    run_seq(5'd7, 2'd1, 4'd11, 2'd1, 1'b0, 1'b0);
    run_seq(5'd29, 2'd3, 4'd5, 2'd2, 1'b1, 1'b0);
    run_seq(5'd3, 2'd2, 4'd7, 2'd0, 1'b1, 1'b0);

    illegal_start(5'd30, 4'd0);
    illegal_start(5'd0, 4'd12);

    // Run, stall at idx 3, attempt a start while busy, then reset mid-run.
    @(posedge clk); #1;
    start = 1'b1; u_in = 5'd2; len_sel = 2'd0; n_cs = 4'd1; n_rep = 2'd0;
    sif.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sif.out_ready = 1'b0;
    start = 1'b1; u_in = 5'd30;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("busy_start_err", err, 0);
    check_eq("busy_start_busy", busy, 1);
    check_eq("mid_idx", sif.out_idx, 3);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_valid", sif.out_valid, 0);
    check_eq("arst_idx", sif.out_idx, 0);
    check_eq("arst_phase", sif.out_phase, 0);
    check_eq("arst_counter", rom_counter, 0);
    check_eq("arst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_done", done, 0);
    run_seq(5'd4, 2'd0, 4'd3, 2'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/low_papr_seq_ctrl.md
Name: low_papr_seq_ctrl

Overview:
- Sequencer for the short low-PAPR base-sequence phase ROMs (length 6/12/18/24, sequence number u = 0..29) used by PUSCH DMRS generation.
- On a start request it latches u, length, cyclic shift and repetition count, then walks the ROM address (counter) element by element.
- For each element it combines the ROM phase code with the cyclic-shift ramp and streams the phase index to the modulator over a valid/ready interface.

Parameters:
- CNT_W, 10, width of ROM counter/address and out_idx
- PH_W, 5, width of output phase index (units of 2π/24, range 0..23)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle request; sampled only when busy=0
- u_in  in  5  sequence number; legal 0..29
- len_sel  in  2  0:M=6, 1:M=12, 2:M=18, 3:M=24
- n_cs  in  4  cyclic shift; legal 0..11
- n_rep  in  2  number of sequence repetitions minus 1 (1..4 repetitions)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last handshake
- err  out  1  one-cycle pulse when start is rejected as illegal
- rom_u  out  5  latched u to the phase ROMs
- rom_sel  out  2  latched len_sel (ROM select)
- rom_counter  out  CNT_W  element index n to the ROMs
- rom_phi  in  2  combinational ROM phase code for (rom_u, rom_counter)
- out_valid  out  1  output element valid
- out_ready  in  1  downstream accept
- out_phase  out  PH_W  phase index 0..23
- out_idx  out  CNT_W  element index n of the presented output
- out_sym_last  out  1  last element of the current repetition
- out_last  out  1  last element of the last repetition

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all internal counters and accumulators 0.
- Encoding decided for this block:
  - ROM code c gives phi = 2c−3 (00→−3, 01→−1, 10→+1, 11→+3).
  - out_phase = (3·phi + 2·n_cs·n) mod 24.
  - 3·phi mod 24 lookup: 00→15, 01→21, 10→3, 11→9.
- Ramp accumulator acc = 2·n_cs·n mod 24:
  - set to 0 at start of each repetition;
  - acc_next = acc + 2·n_cs, subtract 24 once if the sum ≥ 24;
  - final sum reduced mod 24 the same way (single conditional subtract).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start with u_in > 29 or n_cs > 11: err=1 for one cycle, stay in IDLE.
  - Legal start: latch config, counter=0, rep=0, acc=0, busy=1, go to RUN.
- RUN:
  - Single-stage output register.
  - The register loads when (!out_valid || out_ready); the counter then advances.
  - First out_valid is asserted in the cycle after start (latency 1).
  - At n = M−1: out_sym_last=1, counter wraps to 0, acc resets, rep increments.
  - At the final repetition, out_last=1 is set with the final element and no further loads occur.
  - Handshake of the out_last element moves the FSM to DONE.
- Output register:
  - out_valid holds and data stays stable while out_ready=0.
  - Back-to-back throughput is 1 element/cycle while out_ready=1.
- DONE: done=1 for one cycle, busy=0, out_valid=0, return to IDLE. A start in that cycle is ignored.
- start while busy: ignored, no err.
- Async rst mid-run: immediate return to reset state; no done pulse.

Decomposition:
- Shared package holds:
  - len_sel encodings;
  - M lookup (6/12/18/24);
  - U_MAX=29, NCS_MAX=11, PHASE_MOD=24;
  - the 4-entry 3·phi mod 24 table.
- Sub-module low_papr_phase_calc: combinational code+acc → out_phase.
- Phase ROMs stay external, driven through the rom_* ports.

Test Plan:
- u=0, M=6, n_cs=0, n_rep=0, out_ready=1, ROM returning 11,10,01,01,10,11:
  - out_phase = 9,3,21,21,3,9 on consecutive cycles, first at start+1;
  - out_last on idx 5; done one cycle after that handshake.
- Same stimulus with n_cs=1 → out_phase = 9,5,1,3,11,19.
- M=12, n_cs=11, n_rep=1:
  - 24 elements, out_idx 0..11 twice;
  - out_sym_last at 11 and 23 (element counts);
  - acc restarts at 0 for the second repetition; wraps checked against the model.
- Backpressure: out_ready toggling 1,0,0,1 →
  - out_phase and out_idx stable while stalled;
  - no element lost or duplicated; total count = M·(n_rep+1).
- Illegal start: u_in=30 → err pulse, busy stays 0. n_cs=12 → err pulse. start while busy → ignored.
- rst asserted mid-RUN (idx 3), then released:
  - all outputs 0 immediately;
  - a new start produces idx 0 cleanly.
